key_event_tracker: RTL and testbench
====================================

// Module: key_event_tracker
// PURPOSE
//  Downstream of the keycode decoder. Takes its per-key level flags (w,a,s,d,e,space,up,down,right,left)
//  and turns them into debounced held levels, one-cycle press/release pulses and auto-repeat pulses.
//  Sampling advances only on the frame tick, so game logic sees at most one key event per frame.
// PARAMETERS
//  NUM_KEYS       10  number of key channels; bit order 0=w 1=a 2=s 3=d 4=e 5=space 6=up 7=down 8=right 9=left
//  DEBOUNCE_TICKS 2   consecutive equal tick samples needed to accept a change; legal range >=2
//  REPEAT_DELAY   30  ticks in HELD before the first repeat pulse
//  REPEAT_PERIOD  6   ticks between later repeat pulses; legal range 1..REPEAT_DELAY
//  CNT_W          8   counter width; 2**CNT_W > REPEAT_DELAY and 2**CNT_W > DEBOUNCE_TICKS
// PORTS
//  Clk          in   1         system clock; all state changes on its rising edge
//  Reset_n      in   1         asynchronous, active-low reset
//  frame_tick   in   1         one-Clk pulse per frame (vsync-derived); sample/advance enable
//  clr          in   1         synchronous clear; forces every channel to IDLE
//  key_on       in   NUM_KEYS  raw level flags from the keycode decoder
//  key_held     out  NUM_KEYS  debounced level
//  key_press    out  NUM_KEYS  1-cycle pulse when a press is accepted
//  key_release  out  NUM_KEYS  1-cycle pulse when a release is accepted
//  key_repeat   out  NUM_KEYS  1-cycle auto-repeat pulse while held
//  any_held     out  1         OR of key_held
// BEHAVIOUR
//  - Reset (async, Reset_n=0): every channel IDLE, counters 0, all outputs 0 immediately. The key_on input register also clears.
//  - key_on is registered once per Clk (key_q). FSM decisions use key_q and happen only on cycles with frame_tick=1.
//    On every other cycle state and counters hold and all pulse outputs are 0.
//  - Per-channel FSM (dcnt = debounce count, rcnt = repeat count), evaluated on tick cycles:
//    IDLE:    key_q=1 -> DEB_ON, dcnt=1; else stay.
//    DEB_ON:  key_q=0 -> IDLE (no pulse).
//             key_q=1 and dcnt==DEBOUNCE_TICKS-1 -> HELD, press pulse, rcnt=0.
//             otherwise dcnt++.
//    HELD:    key_q=0 -> DEB_OFF, dcnt=1, rcnt frozen.
//             else rcnt++. When the incremented rcnt==REPEAT_DELAY: repeat pulse, rcnt=REPEAT_DELAY-REPEAT_PERIOD.
//    DEB_OFF: key_q=1 -> HELD (rcnt resumes, no pulse).
//             key_q=0 and dcnt==DEBOUNCE_TICKS-1 -> IDLE, release pulse.
//             otherwise dcnt++.
//  - key_held = (state==HELD || state==DEB_OFF). It is registered and changes in the same cycle as the press/release pulse.
//  - Latency: pulses assert on the Clk edge that closes the deciding tick cycle and last exactly 1 Clk.
//    The first key_on=1 sample needs >=1 Clk before a tick to reach key_q.
//  - Repeat pulse and press pulse never coincide on one channel (press leaves rcnt=0 and REPEAT_DELAY>=1).
//  - clr=1: all channels go to IDLE, counters 0, key_held=0, no release pulses, no other pulses that cycle.
//    clr beats a frame_tick in the same cycle.
//  - Channels are independent: several keys may pulse in the same cycle.
//  - Counters never wrap; the parameter constraints above guarantee this.
//  - Reset mid-debounce or mid-hold discards all progress; the key must debounce again afterwards.
// STRUCTURE
//  - Package key_evt_pkg: key index localparams (KEY_W=0 .. KEY_LEFT=9), NUM_KEYS_DEF=10,
//    and typedef enum logic[1:0] {IDLE, DEB_ON, HELD, DEB_OFF} key_state_t.
//  - Sub-module key_channel: one FSM with dcnt/rcnt and the 3 pulse outputs.
//    Top instantiates it NUM_KEYS times with generate, plus the key_q register and the any_held OR-reduce.
// TESTING  (bench params: DEBOUNCE_TICKS=2 REPEAT_DELAY=4 REPEAT_PERIOD=2; tick every 8 Clk)
//  1. key_on[1]=1 for 2 ticks -> key_press=10'h002 for 1 Clk after tick 2; key_held[1]=1; any_held=1.
//  2. key_on[0]=1 for 1 tick, then 0 -> no press pulse, key_held stays 0 (glitch rejected).
//  3. Hold key_on[3] for 10 ticks after the press -> key_repeat[3] pulses after HELD ticks 4,6,8,10; nothing else.
//  4. Held key 3 drops for 1 tick then returns -> no release, key_held[3] stays 1.
//     Then it drops for 2 ticks -> key_release[3] 1-Clk pulse and key_held[3]=0.
//  5. Keys 5 and 6 rise in the same cycle -> key_press=10'h060 in one Clk.
//     clr asserted together with a tick -> key_held=0, no release pulses.
//  6. Reset_n low mid-hold (async, between edges) -> all outputs 0 before the next Clk edge.
//     After Reset_n returns high with key still 1 -> press pulse after 2 further ticks.

Source files
------------

// File: rtl/key_evt_pkg.sv
// key_evt_pkg
//   Shared definitions for the key event tracker: key channel indices,
//   default channel count, per-channel FSM state encoding and the
//   per-channel event bundle returned by key_channel.
package key_evt_pkg;

  // Channel index of each key in the key_on / key_* vectors
  localparam int KEY_W        = 0;
  localparam int KEY_A        = 1;
  localparam int KEY_S        = 2;
  localparam int KEY_D        = 3;
  localparam int KEY_E        = 4;
  localparam int KEY_SPACE    = 5;
  localparam int KEY_UP       = 6;
  localparam int KEY_DOWN     = 7;
  localparam int KEY_RIGHT    = 8;
  localparam int KEY_LEFT     = 9;
  localparam int NUM_KEYS_DEF = 10;

  typedef enum logic [1:0] {IDLE, DEB_ON, HELD, DEB_OFF} key_state_t;

  // Registered outputs of one channel
  typedef struct packed {
    logic held;   // debounced level
    logic press;  // 1-cycle press pulse
    logic rel;    // 1-cycle release pulse
    logic rep;    // 1-cycle auto-repeat pulse
  } key_evt_t;

endpackage

// File: rtl/key_channel.sv
// key_channel
//   Debounce / auto-repeat FSM for a single key. Advances only on tick
//   cycles; clr forces IDLE and wins over tick.
// Ports
//   gclk, grst_n : clock, async active-low reset
//   tick         : frame tick, advance enable
//   clr          : synchronous clear to IDLE
//   key_q        : registered raw key level
//   evt          : registered held level and press/release/repeat pulses
module key_channel
  import key_evt_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int REPEAT_DELAY   = 30,
  parameter int REPEAT_PERIOD  = 6,
  parameter int CNT_W          = 8
) (
  input  logic     gclk,
  input  logic     grst_n,
  input  logic     tick,
  input  logic     clr,
  input  logic     key_q,
  output key_evt_t evt
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_AT     = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  key_state_t       state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] rcnt_inc;

  assign rcnt_inc = rcnt + 1'b1;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
      dcnt  <= '0;
      rcnt  <= '0;
      evt   <= '0;
    end else begin
      // pulses are single-cycle by default
      evt.press <= 1'b0;
      evt.rel   <= 1'b0;
      evt.rep   <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        dcnt     <= '0;
        rcnt     <= '0;
        evt.held <= 1'b0;
      end else if (tick) begin
        case (state)
          IDLE: begin
            if (key_q) begin
              state <= DEB_ON;
              dcnt  <= CNT_W'(1);
            end
          end
          DEB_ON: begin
            if (!key_q) begin
              state <= IDLE;
            end else if (dcnt == DEB_LAST) begin
              state     <= HELD;
              evt.press <= 1'b1;
              evt.held  <= 1'b1;
              rcnt      <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          HELD: begin
            if (!key_q) begin
              // rcnt frozen so a bounce back to HELD resumes the cadence
              state <= DEB_OFF;
              dcnt  <= CNT_W'(1);
            end else if (rcnt_inc == RPT_AT) begin
              evt.rep <= 1'b1;
              rcnt    <= RPT_RELOAD;
            end else begin
              rcnt <= rcnt_inc;
            end
          end
          DEB_OFF: begin
            if (key_q) begin
              state <= HELD;
            end else if (dcnt == DEB_LAST) begin
              state    <= IDLE;
              evt.held <= 1'b0;
              evt.rel  <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_event_tracker.sv
// key_event_tracker
//   Turns raw per-key level flags into debounced held levels and
//   press/release/auto-repeat pulses, advancing once per frame tick.
// Ports
//   Clk, Reset_n : clock, async active-low reset
//   frame_tick   : one-Clk frame pulse, sample/advance enable
//   clr          : synchronous clear of every channel
//   key_on       : raw key levels (bit order per key_evt_pkg indices)
//   key_held     : debounced levels
//   key_press    : press pulses
//   key_release  : release pulses
//   key_repeat   : auto-repeat pulses
//   any_held     : OR of key_held
module key_event_tracker
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS       = NUM_KEYS_DEF,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int REPEAT_DELAY   = 30,
  parameter int REPEAT_PERIOD  = 6,
  parameter int CNT_W          = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_tick,
  input  logic                clr,
  input  logic [NUM_KEYS-1:0] key_on,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_held
);

  logic [NUM_KEYS-1:0] key_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) key_q <= '0;
    else          key_q <= key_on;
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_evt_t evt;

    key_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
    ) u_ch (
      .gclk   (Clk),
      .grst_n (Reset_n),
      .tick   (frame_tick),
      .clr    (clr),
      .key_q  (key_q[i]),
      .evt    (evt)
    );

    assign key_held[i]    = evt.held;
    assign key_press[i]   = evt.press;
    assign key_release[i] = evt.rel;
    assign key_repeat[i]  = evt.rep;
  end

  assign any_held = |key_held;

endmodule

// File: tb/tb_key_event_tracker.sv
module tb_key_event_tracker;
  import key_evt_pkg::*;

  localparam int NK = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_tick;
  logic          clr;
  logic [NK-1:0] key_on;
  logic [NK-1:0] key_held, key_press, key_release, key_repeat;
  logic          any_held;

  always #5 clk = ~clk;

  key_event_tracker #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_TICKS (2),
    .REPEAT_DELAY   (4),
    .REPEAT_PERIOD  (2),
    .CNT_W          (8)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .frame_tick  (frame_tick),
    .clr         (clr),
    .key_on      (key_on),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .any_held    (any_held)
  );

  typedef struct {
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] t;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h expected %h", nm, act, req);
    else passed++;
  endtask

  task automatic push(input string nm, input logic [NK-1:0] p, input logic [NK-1:0] r,
                      input logic [NK-1:0] t);
    exp_t e;
    e.p = p; e.r = r; e.t = t; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with any pulse consumes one expected entry
  task automatic mon_step();
    exp_t e;
    if ((|key_press) || (|key_release) || (|key_repeat)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {2'b0, key_press, key_release, key_repeat}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk(e.name, {2'b0, key_press, key_release, key_repeat}, {2'b0, e.p, e.r, e.t});
      end
    end
  endtask

  // One frame: 7 idle cycles then a tick cycle; returns at the negedge after the tick edge
  task automatic frame(input logic with_clr = 1'b0);
    repeat (7) @(negedge clk);
    frame_tick = 1'b1;
    clr        = with_clr;
    @(negedge clk);
    frame_tick = 1'b0;
    clr        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; clr = 1'b0; key_on = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_outputs", {key_held, key_press, key_release}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. key A debounces in 2 ticks
    key_on[KEY_A] = 1'b1;
    frame();
    push("press_a", 10'h002, '0, '0);
    frame();
    chk("held_a", key_held, 10'h002);
    chk("any_held_a", any_held, 1);
    key_on = '0;
    frame();
    push("release_a", '0, 10'h002, '0);
    frame();
    chk("held_a_off", key_held, 0);

    // 2. one-tick glitch on key W rejected
    key_on[KEY_W] = 1'b1;
    frame();
    key_on = '0;
    frame();
    frame();
    chk("glitch_w_held", key_held, 0);

    // 3. key D held: repeats after HELD ticks 4,6,8,10
    key_on[KEY_D] = 1'b1;
    frame();
    push("press_d", 10'h008, '0, '0);
    frame();
    for (int i = 1; i <= 10; i++) begin
      if (i >= 4 && (i % 2) == 0) push($sformatf("repeat_d_%0d", i), '0, '0, 10'h008);
      frame();
    end

    // 4. one-tick drop ignored, two-tick drop releases
    key_on = '0;
    frame();
    key_on[KEY_D] = 1'b1;
    frame();
    chk("bounce_d_held", key_held, 10'h008);
    key_on = '0;
    frame();
    chk("deb_off_d_held", key_held, 10'h008);
    push("release_d", '0, 10'h008, '0);
    frame();
    chk("released_d_held", key_held, 0);

    // 5. simultaneous press, then clr with tick
    key_on = 10'h060;
    frame();
    push("press_space_up", 10'h060, '0, '0);
    frame();
    chk("held_space_up", key_held, 10'h060);
    key_on = '0;
    frame(1'b1);
    chk("clr_held", key_held, 0);
    chk("clr_any_held", any_held, 0);
    frame();
    frame();
    chk("post_clr_held", key_held, 0);

    // 6. async reset mid-hold, then re-debounce
    key_on[KEY_S] = 1'b1;
    frame();
    push("press_s", 10'h004, '0, '0);
    frame();
    frame();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_held", {key_held, any_held}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame();
    chk("after_reset_deb_held", key_held, 0);
    push("press_s_again", 10'h004, '0, '0);
    frame();
    chk("after_reset_held", key_held, 10'h004);
    key_on = '0;
    frame();
    push("release_s", '0, 10'h004, '0);
    frame();
    repeat (4) @(negedge clk);
    chk("expected_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
